// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: per-stage instructions and
// write enables in, stall/flush/forwarding controls and statistics out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      i_id_inst;
    logic [31:0]      i_ex_inst;
    logic [31:0]      i_mem_inst;
    logic [31:0]      i_wb_inst;
    logic             i_id_rs1_en;
    logic             i_id_rs2_en;
    logic             i_ex_reg_wren;
    logic             i_mem_reg_wren;
    logic             i_wb_reg_wren;
    logic             i_ex_breq;
    logic             i_ex_brlt;
    logic             o_stall;
    logic             o_flush;
    logic [1:0]       o_fwd_rs1;
    logic [1:0]       o_fwd_rs2;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_inst, i_ex_inst, i_mem_inst, i_wb_inst,
        output i_id_rs1_en, i_id_rs2_en,
        output i_ex_reg_wren, i_mem_reg_wren, i_wb_reg_wren,
        output i_ex_breq, i_ex_brlt,
        input  o_stall, o_flush, o_fwd_rs1, o_fwd_rs2, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_inst, i_ex_inst, i_mem_inst, i_wb_inst,
        input  i_id_rs1_en, i_id_rs2_en,
        input  i_ex_reg_wren, i_mem_reg_wren, i_wb_reg_wren,
        input  i_ex_breq, i_ex_brlt,
        output o_stall, o_flush, o_fwd_rs1, o_fwd_rs2, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use scoreboard, branch/jump flush with hold,
// operand forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input logic          i_clk,
    input logic          i_rst_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] LoadInit = 2'(LOAD_LAT - 1);
    localparam logic [1:0] HoldInit = 2'(FLUSH_CYC - 1);
    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpJalr   = 5'b11001;

    logic [4:0] ex_op, mem_op, wb_op;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic [2:0] ex_f3;
    logic       ex_load, mem_load, wb_load;

    assign ex_op    = bus.i_ex_inst[6:2];
    assign mem_op   = bus.i_mem_inst[6:2];
    assign wb_op    = bus.i_wb_inst[6:2];
    assign ex_rd    = bus.i_ex_inst[11:7];
    assign mem_rd   = bus.i_mem_inst[11:7];
    assign wb_rd    = bus.i_wb_inst[11:7];
    assign ex_f3    = bus.i_ex_inst[14:12];
    assign ex_load  = (ex_op == OpLoad);
    assign mem_load = (mem_op == OpLoad);
    assign wb_load  = (wb_op == OpLoad);

    logic [1:0][4:0] rs;
    logic [1:0]      rs_en;

    assign rs[0]    = bus.i_id_inst[19:15];
    assign rs[1]    = bus.i_id_inst[24:20];
    assign rs_en[0] = bus.i_id_rs1_en;
    assign rs_en[1] = bus.i_id_rs2_en;

    logic                unused_bits;
    assign unused_bits = ^{bus.i_id_inst[31:25], bus.i_id_inst[14:0], bus.i_ex_inst[31:15],
                           bus.i_ex_inst[1:0], bus.i_mem_inst[31:12], bus.i_mem_inst[1:0],
                           bus.i_wb_inst[31:12], bus.i_wb_inst[1:0]};

    logic [31:0][1:0] sb_q, sb_d;
    logic [1:0]       hold_q, hold_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       redirect, flush, stall, ld_fire;
    logic [1:0] haz;
    logic [1:0][1:0] fwd;

    always_comb begin
        redirect = 1'b0;
        if (ex_op == OpBranch) begin
            unique case (ex_f3)
                3'b000:          redirect = bus.i_ex_breq;
                3'b001:          redirect = !bus.i_ex_breq;
                3'b100, 3'b110:  redirect = bus.i_ex_brlt;
                3'b101, 3'b111:  redirect = !bus.i_ex_brlt;
                default:         redirect = 1'b0;
            endcase
        end else if (ex_op == OpJal || ex_op == OpJalr) begin
            redirect = 1'b1;
        end
    end

    // Gated by reset so a redirect sitting in EX cannot flush while held in reset.
    assign flush = i_rst_n && (redirect || hold_q != 2'd0);

    // Nearest writer decides; an in-flight load there yields regfile select (the stall covers it).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            haz[i] = 1'b0;
            fwd[i] = 2'd0;
            if (rs_en[i] && rs[i] != 5'd0) begin
                haz[i] = (ex_load && bus.i_ex_reg_wren && ex_rd == rs[i]) ||
                         (sb_q[rs[i]] != 2'd0);
                if (bus.i_ex_reg_wren && ex_rd == rs[i]) begin
                    fwd[i] = ex_load ? 2'd0 : 2'd1;
                end else if (bus.i_mem_reg_wren && mem_rd == rs[i]) begin
                    fwd[i] = (!mem_load || LOAD_LAT == 1) ? 2'd2 : 2'd0;
                end else if (bus.i_wb_reg_wren && wb_rd == rs[i]) begin
                    fwd[i] = (!wb_load || LOAD_LAT <= 2) ? 2'd3 : 2'd0;
                end
            end
        end
    end

    assign stall   = (haz[0] || haz[1]) && !flush;
    assign ld_fire = ex_load && bus.i_ex_reg_wren && ex_rd != 5'd0 && !flush;

    always_comb begin
        sb_d = '0;
        for (int r = 1; r < 32; r++) begin
            if (ld_fire && ex_rd == 5'(r)) begin
                sb_d[r] = LoadInit;
            end else if (sb_q[r] != 2'd0) begin
                sb_d[r] = sb_q[r] - 2'd1;
            end
        end
    end

    always_comb begin
        hold_d = 2'd0;
        if (redirect) begin
            hold_d = HoldInit;
        end else if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (redirect && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_q        <= '0;
            hold_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_flush     = flush;
    assign bus.o_fwd_rs1   = fwd[0];
    assign bus.o_fwd_rs2   = fwd[1];
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven by the same pipeline vectors, with a
// queue of hand-computed expectations popped by a monitor on the falling edge.
module tb_hazard_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned BW = 16;
    localparam logic [5:0] FULL = 6'h3f;
    localparam logic [5:0] FLM  = 6'b010000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst, ex_inst, mem_inst, wb_inst;
    logic        rs1_en, rs2_en, ex_w, mem_w, wb_w, breq, brlt;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(AW)) ifa ();
    hazard_ctrl_if #(.CNT_W(BW)) ifb ();

    assign ifa.i_id_inst      = id_inst;   assign ifb.i_id_inst      = id_inst;
    assign ifa.i_ex_inst      = ex_inst;   assign ifb.i_ex_inst      = ex_inst;
    assign ifa.i_mem_inst     = mem_inst;  assign ifb.i_mem_inst     = mem_inst;
    assign ifa.i_wb_inst      = wb_inst;   assign ifb.i_wb_inst      = wb_inst;
    assign ifa.i_id_rs1_en    = rs1_en;    assign ifb.i_id_rs1_en    = rs1_en;
    assign ifa.i_id_rs2_en    = rs2_en;    assign ifb.i_id_rs2_en    = rs2_en;
    assign ifa.i_ex_reg_wren  = ex_w;      assign ifb.i_ex_reg_wren  = ex_w;
    assign ifa.i_mem_reg_wren = mem_w;     assign ifb.i_mem_reg_wren = mem_w;
    assign ifa.i_wb_reg_wren  = wb_w;      assign ifb.i_wb_reg_wren  = wb_w;
    assign ifa.i_ex_breq      = breq;      assign ifb.i_ex_breq      = breq;
    assign ifa.i_ex_brlt      = brlt;      assign ifb.i_ex_brlt      = brlt;

    hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYC(2), .CNT_W(AW)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYC(1), .CNT_W(BW)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    typedef struct {
        string         name;
        logic [5:0]    exp_a, msk_a, exp_b, msk_b;
        logic          chk_cnt;
        logic [AW-1:0] sc_a, fc_a;
        logic [BW-1:0] sc_b, fc_b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic          cnt_pend = 1'b0;
    logic [AW-1:0] c_sc_a, c_fc_a;
    logic [BW-1:0] c_sc_b, c_fc_b;

    function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] s1,
                                       input logic [4:0] s2);
        return {7'd0, s2, s1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd);
        return {12'd0, 5'd2, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] br(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    function automatic logic [5:0] o(input logic st, input logic fl, input logic [1:0] f1,
                                     input logic [1:0] f2);
        return {st, fl, f1, f2};
    endfunction

    task automatic pipe(input logic [31:0] id, input logic r1, input logic r2,
                        input logic [31:0] ex, input logic ew, input logic [31:0] mem,
                        input logic mw, input logic [31:0] wb, input logic ww);
        id_inst = id;  rs1_en = r1;  rs2_en = r2;
        ex_inst = ex;  ex_w = ew;    mem_inst = mem;  mem_w = mw;
        wb_inst = wb;  wb_w = ww;    breq = 1'b0;     brlt = 1'b0;
    endtask

    task automatic expect_cnt(input logic [AW-1:0] sa, input logic [AW-1:0] fa,
                              input logic [BW-1:0] sb, input logic [BW-1:0] fb);
        cnt_pend = 1'b1;
        c_sc_a = sa;  c_fc_a = fa;  c_sc_b = sb;  c_fc_b = fb;
    endtask

    // Called at posedge+1 after inputs are set; the monitor compares at the next negedge.
    task automatic drive(input string nm, input logic [5:0] ea, input logic [5:0] ma,
                         input logic [5:0] eb, input logic [5:0] mb);
        exp_t e;
        e.name = nm;   e.exp_a = ea;  e.msk_a = ma;  e.exp_b = eb;  e.msk_b = mb;
        e.chk_cnt = cnt_pend;
        e.sc_a = c_sc_a;  e.fc_a = c_fc_a;  e.sc_b = c_sc_b;  e.fc_b = c_fc_b;
        cnt_pend = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {ifa.o_stall, ifa.o_flush, ifa.o_fwd_rs1, ifa.o_fwd_rs2};
                checks++;
                if ((act & e.msk_a) !== (e.exp_a & e.msk_a)) begin
                    failures++;
                    $display("FAIL %s dut_a {stall,flush,fwd1,fwd2} got=%b want=%b mask=%b",
                             e.name, act, e.exp_a, e.msk_a);
                end
                if (e.msk_b != 6'd0) begin
                    act = {ifb.o_stall, ifb.o_flush, ifb.o_fwd_rs1, ifb.o_fwd_rs2};
                    checks++;
                    if ((act & e.msk_b) !== (e.exp_b & e.msk_b)) begin
                        failures++;
                        $display("FAIL %s dut_b {stall,flush,fwd1,fwd2} got=%b want=%b mask=%b",
                                 e.name, act, e.exp_b, e.msk_b);
                    end
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (ifa.o_stall_cnt !== e.sc_a || ifa.o_flush_cnt !== e.fc_a) begin
                        failures++;
                        $display("FAIL %s dut_a counters got stall=%0d flush=%0d want %0d %0d",
                                 e.name, ifa.o_stall_cnt, ifa.o_flush_cnt, e.sc_a, e.fc_a);
                    end
                    checks++;
                    if (ifb.o_stall_cnt !== e.sc_b || ifb.o_flush_cnt !== e.fc_b) begin
                        failures++;
                        $display("FAIL %s dut_b counters got stall=%0d flush=%0d want %0d %0d",
                                 e.name, ifb.o_stall_cnt, ifb.o_flush_cnt, e.sc_b, e.fc_b);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and flush masking while in reset
        expect_cnt(0, 0, 0, 0);
        drive("reset_idle", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, {20'd0, 5'd1, 7'b1101111}, 1, NOP, 0, NOP, 0);
        drive("reset_jal_noflush", o(0, 0, 0, 0), FLM, o(0, 0, 0, 0), FLM);
        rst_n = 1'b1;
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(0, 0, 0, 0);
        drive("post_reset", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        // Load-use: lw x5 then add x6,x5,x1 advancing one stage per cycle
        pipe(rt(6, 5, 1), 1, 1, lw(5), 1, NOP, 0, NOP, 0);
        drive("ldu_ex", o(1, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, NOP, 0, lw(5), 1, NOP, 0);
        drive("ldu_mem", o(1, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, NOP, 0, NOP, 0, lw(5), 1);
        drive("ldu_wb", o(0, 0, 3, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(2, 0, 3, 0);
        drive("ldu_done", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        // Forwarding priority on rs2 = x7
        pipe(rt(1, 2, 7), 1, 1, rt(7, 3, 4), 1, rt(7, 3, 4), 1, NOP, 0);
        drive("fwd_ex_over_mem", o(0, 0, 0, 1), FULL, o(0, 0, 0, 1), FULL);
        pipe(rt(1, 2, 7), 1, 1, rt(0, 3, 4), 1, rt(7, 3, 4), 1, NOP, 0);
        drive("fwd_ex_x0_mem", o(0, 0, 0, 2), FULL, o(0, 0, 0, 2), FULL);
        pipe(rt(1, 2, 7), 1, 1, NOP, 0, NOP, 0, rt(7, 3, 4), 1);
        drive("fwd_wb", o(0, 0, 0, 3), FULL, o(0, 0, 0, 3), FULL);
        pipe(rt(1, 2, 7), 1, 0, rt(7, 3, 4), 1, NOP, 0, NOP, 0);
        drive("fwd_rs2_disabled", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(rt(1, 7, 0), 1, 1, rt(7, 3, 4), 1, lw(7), 1, NOP, 0);
        drive("fwd_young_over_load", o(0, 0, 1, 0), FULL, o(0, 0, 1, 0), FULL);
        pipe(rt(1, 7, 0), 1, 1, NOP, 0, lw(7), 1, NOP, 0);
        drive("fwd_mem_load", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(rt(1, 7, 0), 1, 1, NOP, 0, NOP, 0, lw(7), 1);
        drive("fwd_wb_load", o(0, 0, 3, 0), FULL, o(0, 0, 0, 0), FULL);

        // Taken beq suppresses stall; a load in EX during flush is not scoreboarded
        pipe(rt(6, 5, 1), 1, 1, lw(5), 1, NOP, 0, NOP, 0);
        drive("fl_pre_load", o(1, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, br(3'b000), 0, lw(5), 1, NOP, 0);
        breq = 1'b1;
        drive("fl_beq", o(0, 1, 0, 0), FULL, o(0, 1, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, lw(5), 1, NOP, 0, NOP, 0);
        drive("fl_hold_load", o(0, 1, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(rt(6, 5, 1), 1, 1, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(3, 1, 5, 1);
        drive("fl_after_hold", o(0, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        drive("fl_idle", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        // jal then an x0 load: flush, no stall, no forwarding
        pipe(rt(1, 0, 0), 1, 1, {20'd0, 5'd1, 7'b1101111}, 1, NOP, 0, NOP, 0);
        drive("jal", o(0, 1, 0, 0), FULL, o(0, 1, 0, 0), FULL);
        pipe(rt(1, 0, 0), 1, 1, lw(0), 1, NOP, 0, NOP, 0);
        drive("x0_load_hold", o(0, 1, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(3, 2, 6, 2);
        drive("jal_done", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        // Branch condition decode and hold reload
        pipe(NOP, 0, 0, br(3'b001), 0, NOP, 0, NOP, 0);
        breq = 1'b1;
        drive("bne_not_taken", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, br(3'b100), 0, NOP, 0, NOP, 0);
        brlt = 1'b1;
        drive("blt_taken", o(0, 1, 0, 0), FULL, o(0, 1, 0, 0), FULL);
        pipe(NOP, 0, 0, br(3'b101), 0, NOP, 0, NOP, 0);
        drive("bge_taken_reload", o(0, 1, 0, 0), FULL, o(0, 1, 0, 0), FULL);
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        drive("reload_hold", o(0, 1, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, br(3'b111), 0, NOP, 0, NOP, 0);
        brlt = 1'b1;
        drive("bgeu_not_taken", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, {12'd0, 5'd1, 3'd0, 5'd0, 7'b1100111}, 0, NOP, 0, NOP, 0);
        drive("jalr", o(0, 1, 0, 0), FULL, o(0, 1, 0, 0), FULL);
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        drive("jalr_hold", o(0, 1, 0, 0), FULL, o(0, 0, 0, 0), FULL);
        pipe(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(3, 5, 6, 5);
        drive("branch_done", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        // Saturation: 2^AW+3 forced stall cycles, then reset mid-stall
        pipe(rt(6, 5, 1), 1, 1, lw(5), 1, NOP, 0, NOP, 0);
        for (int i = 0; i < 19; i++) begin
            drive("sat_stall", o(1, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        end
        expect_cnt(4'hf, 5, 25, 5);
        drive("sat_hold", o(1, 0, 0, 0), FULL, o(1, 0, 0, 0), FULL);
        rst_n = 1'b0;
        expect_cnt(0, 0, 0, 0);
        drive("rst_mid_stall", o(0, 0, 0, 0), FLM, o(0, 0, 0, 0), FLM);
        rst_n = 1'b1;
        pipe(rt(6, 5, 1), 1, 1, NOP, 0, NOP, 0, NOP, 0);
        expect_cnt(0, 0, 0, 0);
        drive("sb_empty_after_rst", o(0, 0, 0, 0), FULL, o(0, 0, 0, 0), FULL);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 2, meaning load-data latency in cycles after EX; legal range 1..3.
REQ-002 SHALL have parameter FLUSH_CYC, default 1, meaning the number of cycles o_flush is held per redirect; legal range 1..4.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_id_inst / i_ex_inst / i_mem_inst / i_wb_inst  in  32 each  instruction in each stage.
REQ-007 i_id_rs1_en / i_id_rs2_en  in  1 each  ID instruction reads rs1 / rs2.
REQ-008 i_ex_reg_wren / i_mem_reg_wren / i_wb_reg_wren  in  1 each  stage writes rd.
REQ-009 i_ex_breq / i_ex_brlt  in  1 each  branch comparator results for the EX instruction.
REQ-010 o_stall  out  1  hold PC and IF/ID, inject bubble into EX.
REQ-011 o_flush  out  1  kill IF/ID, redirect PC.
REQ-012 o_fwd_rs1 / o_fwd_rs2  out  2 each  ID operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
REQ-013 o_stall_cnt / o_flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-014 Fields: opcode=[6:2], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20]; a stage "writes r" when its wren=1, rd=r, and r!=0; a load has opcode 5'b00000.
REQ-015 Redirect condition: EX opcode 11000 with funct3 000 and breq, 001 and !breq, 100/110 and brlt, or 101/111 and !brlt; or EX opcode 11011/11001 unconditionally.
REQ-016 On redirect, o_flush SHALL be 1 that cycle and the next FLUSH_CYC-1 cycles, counted by a flush-hold counter; a new redirect during the hold SHALL reload the counter.
REQ-017 Scoreboard: 31 counters (x1..x31), each 2 bits; a load in EX writing r with o_flush=0 SHALL load cnt[r]=LOAD_LAT-1 at the clock edge; every nonzero counter SHALL decrement by 1 per cycle regardless of stall.
REQ-018 Simultaneous load and nonzero count on the same r: load value wins.
REQ-019 Per enabled source rs: hazard = (EX is a load writing rs) or cnt[rs]!=0.
REQ-020 o_stall = (hazard on rs1 or rs2) and o_flush=0; flush suppresses stall.
REQ-021 Forward select per enabled rs, priority EX>MEM>WB: 1 if EX writes rs and is not a load; 2 if MEM writes rs and (not a load or LOAD_LAT=1); 3 if WB writes rs and (not a load or LOAD_LAT<=2); else 0; source disabled or rs=0 -> 0.
REQ-022 Loads forwarded by REQ-021 only after cnt has cleared; a younger non-load writer in a nearer stage SHALL take priority over an older load.
REQ-023 o_stall_cnt increments each cycle o_stall=1; o_flush_cnt increments once per redirect event, not per held cycle; both saturate at all-ones.
REQ-024 o_stall, o_flush and o_fwd_* are combinational from the inputs and state; there is no extra output latency.

Reset
REQ-025 i_rst_n=0 SHALL asynchronously clear all scoreboard counters, the flush-hold counter, and both statistics counters; o_flush=0 while in reset.
REQ-026 Reset asserted mid-stall or mid-flush-hold SHALL abandon that state; the first cycle after release SHALL use only current inputs.

Verification
REQ-027 LOAD_LAT=2: lw x5 in EX, ID add x6,x5,x1 -> o_stall=1 for 2 cycles, third cycle o_stall=0 and o_fwd_rs1=3.
REQ-028 EX beq with breq=1 and FLUSH_CYC=2 -> o_flush=1 for 2 cycles, o_flush_cnt +1, and o_stall=0 throughout even with a load-use hazard present.
REQ-029 EX add x7, MEM add x7, and ID reads x7 on rs2 -> o_fwd_rs2=1, o_stall=0; with the EX instruction writing x0 instead -> o_fwd_rs2=2.
REQ-030 LOAD_LAT=3: lw x9 followed by a 3-cycle ID read of x9 -> stall 3 cycles, then o_fwd_rs1=0.
REQ-031 Force o_stall for 2^CNT_W+3 cycles -> o_stall_cnt holds all-ones; pulse i_rst_n low mid-stall -> counters read 0 and the scoreboard is empty after release.
REQ-032 EX jal, then ID reads x0 with an EX load writing x0 -> o_flush=1, o_stall=0, o_fwd=0.
